viterbi_frame_ctrl: RTL

Frame-level sequencer in front of decoder_sys. Accepts encoded 2-bit symbols over a valid/ready handshake and presents one symbol per enabled cycle to the decoder. After the data it appends K-1 all-zero tail symbols, then drains the decoder's fixed latency. It re-times the decoded bits so that out_valid marks exactly FRAME_LEN data bits per frame and never marks a tail bit.

---
 rtl/viterbi_frame_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/viterbi_frame_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// viterbi_frame_ctrl
// Frame-level sequencer in front of the Viterbi decoder. Accepts FRAME_LEN
// 2-bit encoded symbols over a valid/ready handshake, forwards each one to the
// decoder for a single enabled cycle, appends dec_k-1 all-zero tail symbols,
// then waits out the decoder latency. A tag pipeline travels alongside the
// decoder so that out_valid marks exactly the FRAME_LEN data bits and never a
// tail bit.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_k[2:0]          constraint length request (3..7), sampled on start
//   start               one-cycle frame start request
//   busy                high in LOAD, FLUSH and DRAIN
//   done                one-cycle pulse at frame completion
//   cfg_err             one-cycle pulse after a start with illegal cfg_k
//   in_valid, in_sym    upstream symbol stream
//   in_ready            symbol can be accepted (LOAD only)
//   dec_en, dec_sym     symbol presented to the decoder
//   dec_k               constraint length held for the decoder
//   dec_bit             decoder output bit
//   out_valid, out_bit  re-timed decoded data bit
// -----------------------------------------------------------------------------
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN   = 64,
    parameter int DEC_LATENCY = 16,
    parameter int CNT_W       = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] cfg_k,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       cfg_err,
    input  logic       in_valid,
    input  logic [1:0] in_sym,
    output logic       in_ready,
    output logic       dec_en,
    output logic [1:0] dec_sym,
    output logic [2:0] dec_k,
    input  logic       dec_bit,
    output logic       out_valid,
    output logic       out_bit
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       in_cnt_q, out_cnt_q, en_cnt_q;
    logic [2:0]             tail_cnt_q;
    logic [2:0]             dec_k_q;
    logic                   dec_en_q, dec_data_q;
    logic [1:0]             dec_sym_q;
    logic                   cfg_err_q;
    logic [DEC_LATENCY-1:0] tag_en_q, tag_data_q;
    logic                   out_valid_q, out_bit_q;

    logic cfg_ok, start_ok, accept, load_last, flush_last, pipe_busy, tag_hit;

    assign cfg_ok     = (cfg_k >= 3'd3);
    assign start_ok   = (state_q == S_IDLE) && start && cfg_ok;
    assign accept     = in_valid && in_ready;
    assign load_last  = accept && (in_cnt_q == CNT_W'(FRAME_LEN - 1));
    // FLUSH lasts dec_k-1 cycles; tail_cnt counts from 0, so the last one is dec_k-2.
    assign flush_last = (state_q == S_FLUSH) && (tail_cnt_q == dec_k_q - 3'd2);
    // A symbol still waiting in dec_en_q has not yet entered the tag pipeline.
    assign pipe_busy  = dec_en_q || (|tag_en_q);
    assign tag_hit    = tag_en_q[DEC_LATENCY-1] && tag_data_q[DEC_LATENCY-1];

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: default assignment first so no path leaves state_d unassigned
    // (which would infer a latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_ok)   state_d = S_LOAD;
            S_LOAD:  if (load_last)  state_d = S_FLUSH;
            S_FLUSH: if (flush_last) state_d = S_DRAIN;
            S_DRAIN: if (!pipe_busy) state_d = S_DONE;
            S_DONE:                  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        in_ready = 1'b0;
        unique case (state_q)
            S_LOAD:  begin busy = 1'b1; in_ready = 1'b1; end
            S_FLUSH: busy = 1'b1;
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath ----------------
    // NOTE: the tag pipeline is a few flops, not a memory, so it is reset;
    // stale tags after an aborted frame would otherwise raise out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            en_cnt_q    <= '0;
            tail_cnt_q  <= '0;
            dec_k_q     <= 3'd3;
            dec_en_q    <= 1'b0;
            dec_data_q  <= 1'b0;
            dec_sym_q   <= 2'd0;
            cfg_err_q   <= 1'b0;
            tag_en_q    <= '0;
            tag_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
        end else begin
            cfg_err_q  <= (state_q == S_IDLE) && start && !cfg_ok;
            dec_en_q   <= accept || (state_q == S_FLUSH);
            dec_data_q <= accept;
            if (accept)                  dec_sym_q <= in_sym;
            else if (state_q == S_FLUSH) dec_sym_q <= 2'd0;

            if (start_ok) begin
                dec_k_q    <= cfg_k;
                in_cnt_q   <= '0;
                tail_cnt_q <= '0;
                out_cnt_q  <= '0;
                en_cnt_q   <= '0;
            end else begin
                if (accept)                  in_cnt_q   <= in_cnt_q + 1'b1;
                if (state_q == S_FLUSH)      tail_cnt_q <= tail_cnt_q + 1'b1;
                if (dec_en_q)                en_cnt_q   <= en_cnt_q + 1'b1;
                if (out_valid_q && (out_cnt_q != CNT_W'(FRAME_LEN)))
                    out_cnt_q <= out_cnt_q + 1'b1;
            end

            // Tag entering this cycle lines up with dec_bit DEC_LATENCY cycles later.
            tag_en_q   <= DEC_LATENCY'({tag_en_q, dec_en_q});
            tag_data_q <= DEC_LATENCY'({tag_data_q, dec_data_q});

            out_valid_q <= tag_hit;
            if (tag_hit) out_bit_q <= dec_bit;
        end
    end

    assign cfg_err   = cfg_err_q;
    assign dec_en    = dec_en_q;
    assign dec_sym   = dec_sym_q;
    assign dec_k     = dec_k_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;

    // Internal consistency: at completion both per-frame counts must be exact.
    logic mismatch;
    assign mismatch = (state_q == S_DONE) &&
                      ((out_cnt_q != CNT_W'(FRAME_LEN)) ||
                       (en_cnt_q != CNT_W'(FRAME_LEN) + CNT_W'(dec_k_q) - CNT_W'(1)));

    a_frame_counts: assert property (@(posedge clk) disable iff (!rst_n) !mismatch);

endmodule
